// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp encodings, operand bundle layout and the legal-op check.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned ALU_TAG_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_bundle_t;

  // True for the encodings ALU_ADD through ALU_SRA.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_SRA;
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Decode-side, ALU-side and writeback-side signals of the ALU issue queue.
interface alu_issue_queue_if
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = ALU_TAG_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_DATA_W-1:0] in_a;
  logic [ALU_DATA_W-1:0] in_b;
  logic [ALU_OP_W-1:0]   in_op;
  logic [TAG_W-1:0]      in_tag;

  logic [ALU_DATA_W-1:0] alu_a;
  logic [ALU_DATA_W-1:0] alu_b;
  logic [ALU_OP_W-1:0]   alu_op;
  logic [ALU_DATA_W-1:0] alu_c;

  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_DATA_W-1:0] out_c;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, alu_c, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_tag, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, alu_c, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_tag, out_err
  );
endinterface

// File: rtl/alu_issue_fifo.sv
// In-order bundle storage with wrap-around pointers; head is read straight from storage.
module alu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the execute ALU: queues bundles, feeds the ALU from the head and
// registers the result for writeback. Optional empty-queue bypass: ALU_ISSUE_BYPASS_EN.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ALU_TAG_W
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_queue_if.slave bus
);
  localparam int unsigned W = 2 * ALU_DATA_W + ALU_OP_W + TAG_W;

  logic [W-1:0]          in_word;
  logic [W-1:0]          head_word;
  logic [W-1:0]          last_word;
  logic [W-1:0]          sel_word;
  logic [ALU_DATA_W-1:0] sel_a;
  logic [ALU_DATA_W-1:0] sel_b;
  logic [ALU_OP_W-1:0]   sel_op;
  logic [TAG_W-1:0]      sel_tag;
  logic                  full;
  logic                  empty;
  logic                  free;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  issue;

  logic                  out_valid_q;
  logic [ALU_DATA_W-1:0] out_c_q;
  logic [TAG_W-1:0]      out_tag_q;
  logic                  out_err_q;

  assign in_word = {bus.in_a, bus.in_b, bus.in_op, bus.in_tag};
  assign free    = !out_valid_q || bus.out_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass = empty && bus.in_valid && free;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed bundle goes straight to the result register and never occupies a slot.
  assign push  = bus.in_valid && !full && !bypass;
  assign pop   = !empty && free;
  assign issue = pop || bypass;

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_word),
    .rdata (head_word),
    .full  (full),
    .empty (empty)
  );

  // ALU operand source: bypassed input, queue head, or the last issued bundle when idle.
  always_comb begin
    sel_word = last_word;
    if (bypass)      sel_word = in_word;
    else if (!empty) sel_word = head_word;
  end

  assign {sel_a, sel_b, sel_op, sel_tag} = sel_word;

  // Result register; illegal ops still retire, with a zero result and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      last_word   <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_c_q     <= alu_op_legal(sel_op) ? bus.alu_c : '0;
      out_tag_q   <= sel_tag;
      out_err_q   <= !alu_op_legal(sel_op);
      last_word   <= sel_word;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.alu_a     = sel_a;
  assign bus.alu_b     = sel_b;
  assign bus.alu_op    = sel_op;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed vectors, corner sequences, randomized scoreboard.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU; unimplemented ops return junk that the queue must suppress.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a >> b[4:0];
      3'd5:    return 32'($signed(a) >>> b[4:0]);
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb bus.alu_c = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  task automatic chk_result(input string name, input logic [31:0] c, input logic [4:0] tag,
                            input logic err);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({name, "_c"},     64'(bus.out_c),     64'(c));
    chk({name, "_tag"},   64'(bus.out_tag),   64'(tag));
    chk({name, "_err"},   64'(bus.out_err),   64'(err));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"},  64'(bus.in_ready),  64'(1));
    chk({name, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({name, "_out_c"},     64'(bus.out_c),     64'(0));
    chk({name, "_out_tag"},   64'(bus.out_tag),   64'(0));
    chk({name, "_out_err"},   64'(bus.out_err),   64'(0));
    chk({name, "_alu_a"},     64'(bus.alu_a),     64'(0));
    chk({name, "_alu_b"},     64'(bus.alu_b),     64'(0));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] c;
    logic        err;
  } vec_t;

  vec_t        vt[10];
  alu_bundle_t exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  tag_ctr;
    logic [31:0] exp_c;
    logic        exp_err;
    alu_bundle_t e;
    int          drain;

    vt[0] = '{32'd5,         32'd3,      3'b000, 5'd7,  32'd8,         1'b0};
    vt[1] = '{32'd3,         32'd5,      3'b001, 5'd1,  32'hFFFF_FFFE, 1'b0};
    vt[2] = '{32'h0000_F0F0, 32'h0000_FF00, 3'b010, 5'd2, 32'h0000_F000, 1'b0};
    vt[3] = '{32'h0000_F0F0, 32'h0000_0F0F, 3'b011, 5'd3, 32'h0000_FFFF, 1'b0};
    vt[4] = '{32'h0000_00F0, 32'd4,      3'b100, 5'd4,  32'h0000_000F, 1'b0};
    vt[5] = '{32'h8000_0000, 32'd4,      3'b101, 5'd5,  32'hF800_0000, 1'b0};
    vt[6] = '{32'h0000_1234, 32'd1,      3'b110, 5'd6,  32'd0,         1'b1};
    vt[7] = '{32'd9,         32'd9,      3'b111, 5'd31, 32'd0,         1'b1};
    vt[8] = '{32'hFFFF_FFFF, 32'd1,      3'b000, 5'd0,  32'd0,         1'b0};
    vt[9] = '{32'h8000_0000, 32'd31,     3'b100, 5'd8,  32'd1,         1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed vectors, one at a time, out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
      step();
      bus.in_valid = 1'b0;
      for (int k = 1; k < LAT; k++) begin
        chk($sformatf("vec%0d_latency", i), 64'(bus.out_valid), 64'(0));
        step();
      end
      chk_result($sformatf("vec%0d", i), vt[i].c, vt[i].tag, vt[i].err);
    end
    step();
    chk("idle_after_vectors", 64'(bus.out_valid), 64'(0));

    // Illegal op followed immediately by a legal op
    drive(32'd7, 32'd7, 3'b110, 5'd20);
    step();
`ifdef ALU_ISSUE_BYPASS_EN
    chk_result("illegal_first", 32'd0, 5'd20, 1'b1);
    drive(32'd1, 32'd2, ALU_ADD, 5'd21);
    step();
    bus.in_valid = 1'b0;
    chk_result("legal_next", 32'd3, 5'd21, 1'b0);
`else
    drive(32'd1, 32'd2, ALU_ADD, 5'd21);
    step();
    bus.in_valid = 1'b0;
    chk_result("illegal_first", 32'd0, 5'd20, 1'b1);
    step();
    chk_result("legal_next", 32'd3, 5'd21, 1'b0);
`endif
    step();

    // Fill: one result held in the output register, then four bundles fill the queue
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'(100 + i), 32'd1, ALU_ADD, 5'(9 + i));
      step();
      if (i == 3) chk("fill_ready_before_full", 64'(bus.in_ready), 64'(1));
    end
    chk("fill_full", 64'(bus.in_ready), 64'(0));
    drive(32'd500, 32'd1, ALU_ADD, 5'd14);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("fill_still_full", 64'(bus.in_ready), 64'(0));
    chk_result("fill_hold", 32'd101, 5'd9, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk_result($sformatf("drain%0d", i), 32'(101 + i), 5'(9 + i), 1'b0);
    end
    step();
    chk("drain_no_extra", 64'(bus.out_valid), 64'(0));

    // Asynchronous reset mid-stream: three queued and one result pending
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'(40 + i), 32'd2, ALU_SUB, 5'(1 + i));
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_reset_valid", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("post_reset_empty", 64'(bus.out_valid), 64'(0));
    drive(32'd10, 32'd20, ALU_OR, 5'd17);
    step();
    bus.in_valid = 1'b0;
    repeat (LAT - 1) step();
    chk_result("post_reset_push", 32'd30, 5'd17, 1'b0);
    step();

    // Randomized traffic against a scoreboard of pushed bundles
    tag_ctr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (($urandom % 4) != 0)
        drive($urandom, $urandom, 3'($urandom % 8), tag_ctr);
      else
        bus.in_valid = 1'b0;
      bus.out_ready = (cyc % 2 == 0) ? 1'b1 : 1'($urandom % 2);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          exp_err = (e.op > 3'd5);
          exp_c   = exp_err ? 32'd0 : alu_fn(e.a, e.b, e.op);
          chk("rand_result", {25'd0, bus.out_c, bus.out_tag, bus.out_err},
              {25'd0, exp_c, e.tag, exp_err});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{bus.in_a, bus.in_b, bus.in_op, bus.in_tag});
        tag_ctr = tag_ctr + 5'd1;
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain = 0;
    while (drain < 20 && (exp_q.size() != 0 || bus.out_valid)) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          exp_err = (e.op > 3'd5);
          exp_c   = exp_err ? 32'd0 : alu_fn(e.a, e.b, e.op);
          chk("drain_result", {25'd0, bus.out_c, bus.out_tag, bus.out_err},
              {25'd0, exp_c, e.tag, exp_err});
        end
      end
      step();
      drain++;
    end
    chk("rand_all_retired", 64'(exp_q.size()), 64'(0));
    chk("rand_idle", 64'(bus.out_valid), 64'(0));

`ifdef ALU_ISSUE_BYPASS_EN
    // Empty-queue bypass: one-edge latency, nothing left in the queue
    drive(32'h0000_00F0, 32'd4, ALU_SRL, 5'd3);
    step();
    bus.in_valid = 1'b0;
    chk_result("bypass", 32'h0000_000F, 5'd3, 1'b0);
    step();
    chk("bypass_queue_empty", 64'(bus.out_valid), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Buffered issue stage placed directly upstream of the execute-stage ALU. It accepts operand bundles {A, B, ALUOp, tag} from decode over a valid/ready handshake and queues them in order. The head bundle drives the combinational ALU, and the ALU result is captured into an output register presented to writeback over a second valid/ready handshake. It decouples decode stalls from writeback stalls and flags ALUOp encodings the ALU does not implement.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- TAG_W, 5, width of the destination tag carried alongside each bundle
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents a bundle
- in_ready  output  1  queue can accept a bundle
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_op  input  3  ALUOp
- in_tag  input  TAG_W  destination tag
- alu_a  output  32  to ALU A
- alu_b  output  32  to ALU B
- alu_op  output  3  to ALU ALUOp
- alu_c  input  32  ALU result C (combinational return)
- out_valid  output  1  result register holds a result
- out_ready  input  1  writeback accepts the result
- out_c  output  32  registered result
- out_tag  output  TAG_W  registered tag
- out_err  output  1  result came from an illegal ALUOp

## Operation
- Push: in_valid && in_ready writes the bundle at the write pointer; pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH); it does not depend on a same-cycle pop.
- Head entry drives alu_a/alu_b/alu_op continuously, registered storage only; when the queue is empty these outputs hold the last head contents (zero after reset).
- Issue/pop: head valid && (!out_valid || out_ready) loads the result register and pops the head in the same edge.
- Legal ops 3'b000–3'b101: out_c <= alu_c, out_err <= 0. Illegal ops 3'b110/3'b111: out_c <= 0, out_err <= 1, and the entry is still popped.
- B is passed unmodified; shift-amount interpretation belongs to the ALU.
- Output handshake: out_valid && out_ready consumes the result. out_valid clears unless a new issue occurs on the same edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset, asserted at any time including mid-operation: count=0, pointers=0, storage=0, out_valid=0, out_c=0, out_tag=0, out_err=0. The in_ready reset value is 1.

## Timing
- Default latency: bundle pushed on edge N → at head during cycle N+1 → out_valid high after edge N+1. Two edges from push to result.
- Sustained throughput is one bundle per cycle when out_ready is held high.
- out_valid/out_c/out_tag/out_err change only on clk edges and are stable while out_valid && !out_ready.
- in_ready is a registered-state function only (count), with no combinational path from out_ready.

## Configuration
- ALU_ISSUE_BYPASS_EN defined: when the queue is empty, in_valid is high and the result register is free (!out_valid || out_ready), the incoming bundle drives alu_a/alu_b/alu_op combinationally and is captured directly into the result register without being written to the queue. Latency is 1 edge.
- ALU_ISSUE_BYPASS_EN undefined: every bundle passes through the queue, and latency is always 2 edges.
- All other behaviour is identical in both builds.

## Structure
- Shared package alu_pkg:
  - ALUOp constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SRL=3'b100, ALU_SRA=3'b101
  - function alu_op_legal(op)
  - bundle typedef {a, b, op, tag}
- Sub-module alu_issue_fifo: storage array, wrap-around pointers, count, full/empty.
- The top level holds the bypass mux, the issue logic and the result register.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-stream with 3 entries queued and out_valid=1 → next cycle count=0, out_valid=0, in_ready=1, alu_a=alu_b=0.
- Push {A=5, B=3, op=ADD, tag=7} with out_ready=1 and no bypass → out_valid rises 2 edges later with out_c=8 (ALU model returning 8), out_tag=7, out_err=0.
- Push 4 bundles with out_ready=0 → in_ready=0 after the 4th push. A 5th in_valid is not accepted. Raising out_ready drains them in order, one per cycle.
- Push op=3'b110 → result has out_c=0 and out_err=1. The following legal bundle issues normally in the next cycle.
- Steady push and pop with alternating out_ready → no loss or duplication across pointer wrap (≥3 wraps), and tags emerge in push order.
- With ALU_ISSUE_BYPASS_EN, an empty queue and a push of {A=32'hF0, B=4, op=SRL} → out_valid after 1 edge with out_c=32'h0F, and the queue count stays 0.
